axil_cfg_master: RTL and testbench

//  Synthesizable AXI4-Lite initiator: the driving end of the Garnet axi4_slave_* config port.

---
 rtl/axil_cfg_master.sv | 251 +++++++++++++++++++++++++
 tb/tb_axil_cfg_master.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_cfg_master.sv
// AXI4-Lite initiator for the config port: one command in, one AXI4-Lite transaction out,
// one response back. A wait-state timeout aborts hung transactions and reports them.
module axil_cfg_master #(
    parameter int unsigned ADDR_WIDTH     = 13,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    // command / response
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0] cmd_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_write,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic                  rsp_timeout,
    output logic                  timeout_sticky,
    // AXI4-Lite write address / data / response
    output logic [ADDR_WIDTH-1:0] axi4_master_awaddr,
    output logic                  axi4_master_awvalid,
    input  logic                  axi4_master_awready,
    output logic [DATA_WIDTH-1:0] axi4_master_wdata,
    output logic                  axi4_master_wvalid,
    input  logic                  axi4_master_wready,
    input  logic [1:0]            axi4_master_bresp,
    input  logic                  axi4_master_bvalid,
    output logic                  axi4_master_bready,
    // AXI4-Lite read address / data
    output logic [ADDR_WIDTH-1:0] axi4_master_araddr,
    output logic                  axi4_master_arvalid,
    input  logic                  axi4_master_arready,
    input  logic [DATA_WIDTH-1:0] axi4_master_rdata,
    input  logic [1:0]            axi4_master_rresp,
    input  logic                  axi4_master_rvalid,
    output logic                  axi4_master_rready
);

    localparam int unsigned    CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]     RESP_SLVERR = 2'b10;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WADDR = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_RADDR = 3'd3;
    localparam logic [2:0] S_RDATA = 3'd4;
    localparam logic [2:0] S_RESP  = 3'd5;

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic                  rsp_timeout_q, rsp_timeout_d;
    logic                  sticky_q, sticky_d;

    logic                  aw_done_c;
    logic                  w_done_c;
    logic                  expired_c;
    logic                  abort_c;

    // Next-state and output logic; abort overrides whatever the wait state decided.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        cmd_ready_d   = cmd_ready_q;
        awvalid_d     = awvalid_q;
        wvalid_d      = wvalid_q;
        bready_d      = bready_q;
        arvalid_d     = arvalid_q;
        rready_d      = rready_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_write_d   = rsp_write_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_resp_d    = rsp_resp_q;
        rsp_timeout_d = rsp_timeout_q;
        sticky_d      = sticky_q;
        abort_c       = 1'b0;
        aw_done_c     = !awvalid_q || axi4_master_awready;
        w_done_c      = !wvalid_q || axi4_master_wready;
        expired_c     = (cnt_q >= CNT_LIMIT);

        // Counter saturates at the limit so a late phase change can never wrap it.
        if ((state_q == S_WADDR) || (state_q == S_WRESP) ||
            (state_q == S_RADDR) || (state_q == S_RDATA)) begin
            if (!expired_c) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr;
                    wdata_d     = cmd_wdata;
                    rsp_write_d = cmd_write;
                    cnt_d       = '0;
                    if (cmd_write) begin
                        state_d   = S_WADDR;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                    end else begin
                        state_d   = S_RADDR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_WADDR: begin
                awvalid_d = awvalid_q && !axi4_master_awready;
                wvalid_d  = wvalid_q && !axi4_master_wready;
                if (aw_done_c && w_done_c) begin
                    state_d  = S_WRESP;
                    bready_d = 1'b1;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                end
            end
            S_WRESP: begin
                if (axi4_master_bvalid) begin
                    state_d       = S_RESP;
                    bready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi4_master_bresp;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b0;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                end
            end
            S_RADDR: begin
                if (axi4_master_arready) begin
                    state_d   = S_RDATA;
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                end
            end
            S_RDATA: begin
                if (axi4_master_rvalid) begin
                    state_d       = S_RESP;
                    rready_d      = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_resp_d    = axi4_master_rresp;
                    rsp_rdata_d   = axi4_master_rdata;
                    rsp_timeout_d = 1'b0;
                end else if (expired_c) begin
                    abort_c = 1'b1;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Hung-slave recovery: drop every AXI handshake signal and report the abort.
        if (abort_c) begin
            state_d       = S_RESP;
            awvalid_d     = 1'b0;
            wvalid_d      = 1'b0;
            bready_d      = 1'b0;
            arvalid_d     = 1'b0;
            rready_d      = 1'b0;
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_resp_d    = RESP_SLVERR;
            rsp_rdata_d   = '0;
            sticky_d      = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            cnt_q         <= '0;
            cmd_ready_q   <= 1'b0;
            awvalid_q     <= 1'b0;
            wvalid_q      <= 1'b0;
            bready_q      <= 1'b0;
            arvalid_q     <= 1'b0;
            rready_q      <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_write_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_resp_q    <= '0;
            rsp_timeout_q <= 1'b0;
            sticky_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cmd_ready_q   <= cmd_ready_d;
            awvalid_q     <= awvalid_d;
            wvalid_q      <= wvalid_d;
            bready_q      <= bready_d;
            arvalid_q     <= arvalid_d;
            rready_q      <= rready_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_write_q   <= rsp_write_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_resp_q    <= rsp_resp_d;
            rsp_timeout_q <= rsp_timeout_d;
            sticky_q      <= sticky_d;
        end
    end

    assign cmd_ready           = cmd_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_write           = rsp_write_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_resp            = rsp_resp_q;
    assign rsp_timeout         = rsp_timeout_q;
    assign timeout_sticky      = sticky_q;
    assign axi4_master_awaddr  = addr_q;
    assign axi4_master_awvalid = awvalid_q;
    assign axi4_master_wdata   = wdata_q;
    assign axi4_master_wvalid  = wvalid_q;
    assign axi4_master_bready  = bready_q;
    assign axi4_master_araddr  = addr_q;
    assign axi4_master_arvalid = arvalid_q;
    assign axi4_master_rready  = rready_q;

endmodule

// File: tb/tb_axil_cfg_master.sv
// Directed bench for axil_cfg_master: a table of commands with per-channel slave delays and
// hand-computed responses/latencies, plus hand-written reset sequences.
module tb_axil_cfg_master;

    localparam int unsigned AW    = 13;
    localparam int unsigned DW    = 32;
    localparam int unsigned TO    = 16;
    localparam int          NEVER = 1000;
    localparam int          NVEC  = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_write, rsp_timeout, timeout_sticky;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;
    logic [AW-1:0] awaddr, araddr;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [DW-1:0] wdata, rdata;
    logic [1:0]    bresp, rresp;

    always #5 clk = ~clk;

    axil_cfg_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .timeout_sticky(timeout_sticky),
        .axi4_master_awaddr(awaddr), .axi4_master_awvalid(awvalid), .axi4_master_awready(awready),
        .axi4_master_wdata(wdata), .axi4_master_wvalid(wvalid), .axi4_master_wready(wready),
        .axi4_master_bresp(bresp), .axi4_master_bvalid(bvalid), .axi4_master_bready(bready),
        .axi4_master_araddr(araddr), .axi4_master_arvalid(arvalid), .axi4_master_arready(arready),
        .axi4_master_rdata(rdata), .axi4_master_rresp(rresp), .axi4_master_rvalid(rvalid),
        .axi4_master_rready(rready)
    );

    typedef struct {
        string       name;
        logic        wr;
        logic [12:0] addr;
        logic [31:0] wdata;
        int          a_dly;     // cycles AW/AR valid before ready
        int          w_dly;     // cycles W valid before ready
        int          x_dly;     // cycles after address phase before B/R valid
        logic [1:0]  sresp;
        logic [31:0] srdata;
        int          hold;      // cycles rsp_ready held low after rsp_valid
        int          exp_lat;   // cycle of first rsp_valid, cmd handshake = cycle 0
        logic [1:0]  exp_resp;
        logic [31:0] exp_rdata;
        logic        exp_to;
        logic        exp_sticky;
        int          exp_a_cyc;
        int          exp_w_cyc;
        int          exp_a_hs;
        int          exp_w_hs;
        int          exp_x_hs;
        int          exp_xwin;
    } vec_t;

    vec_t tbl [NVEC];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_slave();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;
    endtask

    task automatic run_vec(input vec_t v);
        int a_cnt = 0, w_cnt = 0, x_cnt = 0;
        int a_cyc = 0, w_cyc = 0, a_hs = 0, w_hs = 0, x_hs = 0, xwin = 0;
        int lat = -1, hold_left = 0, viol = 0, busy_viol = 0, wait_n = 0;
        bit a_done = 0, w_done = 0, x_done = 0, x_rdy_prev = 0;
        bit got = 0, rsp_hs = 0, finished = 0;
        bit a_v, x_rdy, x_v, a_r, w_r;
        logic [AW-1:0] a_addr;
        logic [35:0]   cap;

        while (!cmd_ready && wait_n < 10) begin
            @(negedge clk);
            wait_n++;
        end
        chk({v.name, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1; cmd_write = v.wr; cmd_addr = v.addr; cmd_wdata = v.wdata;
        @(posedge clk);
        for (int c = 1; c <= 60 && !finished; c++) begin
            @(negedge clk);
            if (c == 1) begin
                cmd_valid = 1'b0; cmd_write = ~v.wr; cmd_addr = ~v.addr; cmd_wdata = ~v.wdata;
            end
            if (rsp_hs) begin
                chk({v.name, "_ready_after_rsp"}, 32'({cmd_ready, rsp_valid}), 32'b10);
                rsp_ready = 1'b0;
                finished  = 1'b1;
            end else begin
                if (cmd_ready) busy_viol++;
                a_v    = v.wr ? awvalid : arvalid;
                a_addr = v.wr ? awaddr : araddr;
                x_rdy  = v.wr ? bready : rready;
                if (a_v) begin
                    a_cyc++;
                    if (a_addr !== v.addr) viol++;
                end
                if (wvalid) begin
                    w_cyc++;
                    if (wdata !== v.wdata) viol++;
                end
                if (x_rdy && !x_rdy_prev) xwin++;
                x_rdy_prev = x_rdy;
                // Response channel uses address-phase completion from earlier cycles only.
                x_v = 1'b0;
                if (a_done && (w_done || !v.wr) && !x_done) begin
                    x_v = (x_cnt >= v.x_dly);
                    x_cnt++;
                    if (x_v && x_rdy) begin
                        x_hs++;
                        x_done = 1'b1;
                    end
                end
                a_r = 1'b0;
                if (a_v) begin
                    a_r = (a_cnt == v.a_dly);
                    a_cnt++;
                    if (a_r) begin a_hs++; a_done = 1'b1; end
                end
                w_r = 1'b0;
                if (wvalid) begin
                    w_r = (w_cnt == v.w_dly);
                    w_cnt++;
                    if (w_r) begin w_hs++; w_done = 1'b1; end
                end
                rdata = v.wr ? 32'hBAD0BAD0 : v.srdata;
                if (v.wr) begin
                    awready = a_r; wready = w_r; bvalid = x_v; bresp = v.sresp;
                end else begin
                    arready = a_r; rvalid = x_v; rresp = v.sresp;
                end
                if (got && !rsp_valid) viol++;
                if (rsp_valid) begin
                    if (!got) begin
                        got = 1'b1;
                        lat = c;
                        cap = {rsp_write, rsp_timeout, rsp_resp, rsp_rdata};
                        hold_left = v.hold;
                        chk({v.name, "_sticky"}, 32'(timeout_sticky), 32'(v.exp_sticky));
                    end else if ({rsp_write, rsp_timeout, rsp_resp, rsp_rdata} !== cap) begin
                        viol++;
                    end
                    if (hold_left == 0) begin
                        rsp_ready = 1'b1;
                        rsp_hs    = 1'b1;
                    end else begin
                        rsp_ready = 1'b0;
                        hold_left--;
                    end
                end
            end
        end
        idle_slave();
        rsp_ready = 1'b0;
        cmd_valid = 1'b0;
        chk({v.name, "_completed"}, 32'(finished), 32'd1);
        chk({v.name, "_latency"}, 32'(lat), 32'(v.exp_lat));
        chk({v.name, "_rsp_write"}, 32'(cap[35]), 32'(v.wr));
        chk({v.name, "_rsp_timeout"}, 32'(cap[34]), 32'(v.exp_to));
        chk({v.name, "_rsp_resp"}, 32'(cap[33:32]), 32'(v.exp_resp));
        chk({v.name, "_rsp_rdata"}, cap[31:0], v.exp_rdata);
        chk({v.name, "_addr_valid_cycles"}, 32'(a_cyc), 32'(v.exp_a_cyc));
        chk({v.name, "_wvalid_cycles"}, 32'(w_cyc), 32'(v.exp_w_cyc));
        chk({v.name, "_addr_handshakes"}, 32'(a_hs), 32'(v.exp_a_hs));
        chk({v.name, "_w_handshakes"}, 32'(w_hs), 32'(v.exp_w_hs));
        chk({v.name, "_resp_handshakes"}, 32'(x_hs), 32'(v.exp_x_hs));
        chk({v.name, "_resp_ready_windows"}, 32'(xwin), 32'(v.exp_xwin));
        chk({v.name, "_stability_violations"}, 32'(viol), 32'd0);
        chk({v.name, "_cmd_ready_while_busy"}, 32'(busy_viol), 32'd0);
    endtask

    initial begin
        //            name           wr    addr      wdata         a_dly w_dly x_dly sresp  srdata        hold lat resp   rdata         to    sticky acyc wcyc ahs whs xhs xwin
        tbl[0]  = '{"wr_zero",      1'b1, 13'h0100, 32'hDEADBEEF, 0,    0,    0,    2'b00, 32'h0,        0,   3,  2'b00, 32'h0,        1'b0, 1'b0,  1,   1,   1,  1,  1,  1};
        tbl[1]  = '{"rd_ar5",       1'b0, 13'h0104, 32'h0,        5,    0,    0,    2'b00, 32'h12345678, 0,   8,  2'b00, 32'h12345678, 1'b0, 1'b0,  6,   0,   1,  0,  1,  1};
        tbl[2]  = '{"wr_w_first",   1'b1, 13'h0108, 32'hA5A50F0F, 4,    0,    0,    2'b00, 32'h0,        0,   7,  2'b00, 32'h0,        1'b0, 1'b0,  5,   1,   1,  1,  1,  1};
        tbl[3]  = '{"wr_aw_first",  1'b1, 13'h010C, 32'h01234567, 0,    3,    2,    2'b00, 32'h0,        0,   8,  2'b00, 32'h0,        1'b0, 1'b0,  1,   4,   1,  1,  1,  1};
        tbl[4]  = '{"wr_slverr",    1'b1, 13'h0110, 32'h0000FFFF, 0,    0,    0,    2'b10, 32'h0,        0,   3,  2'b10, 32'h0,        1'b0, 1'b0,  1,   1,   1,  1,  1,  1};
        tbl[5]  = '{"rd_decerr",    1'b0, 13'h0114, 32'h0,        0,    0,    1,    2'b11, 32'hCAFE0001, 0,   4,  2'b11, 32'hCAFE0001, 1'b0, 1'b0,  1,   0,   1,  0,  1,  1};
        tbl[6]  = '{"wr_b_hang",    1'b1, 13'h0118, 32'h5555AAAA, 0,    0,    NEVER,2'b00, 32'h0,        0,   17, 2'b10, 32'h0,        1'b1, 1'b1,  1,   1,   1,  1,  0,  1};
        tbl[7]  = '{"rd_after_to",  1'b0, 13'h0004, 32'h0,        0,    0,    0,    2'b00, 32'h00000055, 0,   3,  2'b00, 32'h00000055, 1'b0, 1'b1,  1,   0,   1,  0,  1,  1};
        tbl[8]  = '{"rd_r_last",    1'b0, 13'h0008, 32'h0,        0,    0,    14,   2'b00, 32'h0BADF00D, 0,   17, 2'b00, 32'h0BADF00D, 1'b0, 1'b1,  1,   0,   1,  0,  1,  1};
        tbl[9]  = '{"rd_r_late",    1'b0, 13'h000C, 32'h0,        0,    0,    15,   2'b00, 32'h77777777, 0,   17, 2'b10, 32'h0,        1'b1, 1'b1,  1,   0,   1,  0,  0,  1};
        tbl[10] = '{"rd_ar_hang",   1'b0, 13'h0010, 32'h0,        NEVER,0,    0,    2'b00, 32'h00000001, 0,   17, 2'b10, 32'h0,        1'b1, 1'b1,  16,  0,   0,  0,  0,  0};
        tbl[11] = '{"wr_aw_hang",   1'b1, 13'h0014, 32'h13579BDF, NEVER,0,    0,    2'b00, 32'h0,        0,   17, 2'b10, 32'h0,        1'b1, 1'b1,  16,  1,   0,  1,  0,  0};
        tbl[12] = '{"rd_rsp_hold",  1'b0, 13'h1FFC, 32'h0,        0,    0,    0,    2'b01, 32'hFFFFFFFF, 10,  3,  2'b01, 32'hFFFFFFFF, 1'b0, 1'b1,  1,   0,   1,  0,  1,  1};
        tbl[13] = '{"wr_b_slow",    1'b1, 13'h0020, 32'h80000001, 1,    2,    3,    2'b00, 32'h0,        0,   8,  2'b00, 32'h0,        1'b0, 1'b1,  2,   3,   1,  1,  1,  1};

        reset = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        idle_slave();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_handshake_outputs",
            32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("reset_rsp_fields", 32'({rsp_write, rsp_timeout, rsp_resp, timeout_sticky}), 32'd0);
        chk("reset_rsp_rdata", rsp_rdata, 32'd0);
        chk("reset_addr_data", 32'({awaddr, araddr}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

        for (int i = 0; i < NVEC; i++) begin
            run_vec(tbl[i]);
        end

        // Reset pulsed while the read waits for R data.
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h0030; cmd_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("rst_mid_arvalid", 32'(arvalid), 32'd1);
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        chk("rst_mid_in_rdata", 32'({arvalid, rready}), 32'b01);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_handshake_outputs",
            32'({cmd_ready, rsp_valid, awvalid, wvalid, bready, arvalid, rready}), 32'd0);
        chk("rst_mid_sticky_cleared", 32'(timeout_sticky), 32'd0);
        chk("rst_mid_rsp_fields", 32'({rsp_write, rsp_timeout, rsp_resp}), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_back_to_idle", 32'({cmd_ready, rready, arvalid}), 32'b100);

        run_vec(tbl[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
